// File: rtl/seq_starter_if.sv
// rtl/seq_starter_if.sv - request/acknowledge handshake bundle between seq_starter and its downstream calculator
interface seq_starter_if #(
  parameter int ADDR_W = 4
);
  logic              req_1;
  logic              ack_1;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;

  modport master (output req_1, output address, output busy, output done, input ack_1);
  modport slave  (input req_1, input address, input busy, input done, output ack_1);
endinterface

// File: rtl/seq_starter.sv
// rtl/seq_starter.sv - push-button started ROM address sequencer with four-phase req/ack handshake
// Optional key debounce filter enabled by defining SEQ_STARTER_DEBOUNCE_EN.
module seq_starter #(
  parameter int ADDR_W     = 4,
  parameter int LAST_ADDR  = 2**ADDR_W-1,
  parameter int DEB_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key1,
  input  logic          mode,
  seq_starter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARMED, REQ, ACK_LOW} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  if (DEB_CYCLES < 2 || LAST_ADDR > 2**ADDR_W-1 || LAST_ADDR < 0) begin : g_bad_param
    $error("seq_starter: DEB_CYCLES must be >= 2 and LAST_ADDR must fit in ADDR_W bits");
  end

  state_t            state;
  logic [ADDR_W-1:0] address;
  logic              run_mode;
  logic              done;
  logic              key_s1;
  logic              key_s2;
  logic              key;

  // Flops reset to the released level so a key held low through reset reads as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= key1;
      key_s2 <= key_s1;
    end
  end

`ifdef SEQ_STARTER_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] deb_cnt;
  logic             key_deb;

  // Counts consecutive samples that disagree with the filtered level; any agreement restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt <= '0;
      key_deb <= 1'b1;
    end else if (key_s2 == key_deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_MAX) begin
      deb_cnt <= '0;
      key_deb <= key_s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign key = key_deb;
`else
  assign key = key_s2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      address  <= '0;
      run_mode <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!key) state <= ARMED;
        end
        ARMED: begin
          if (key) begin
            state    <= REQ;
            run_mode <= mode;
          end
        end
        REQ: begin
          if (bus.ack_1) state <= ACK_LOW;
        end
        ACK_LOW: begin
          if (!bus.ack_1) begin
            if (address == LAST) begin
              address <= '0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              address <= address + 1'b1;
              state   <= run_mode ? REQ : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded from the state register alone so reset drops req_1 immediately.
  assign bus.req_1   = (state == REQ);
  assign bus.busy    = (state == REQ) || (state == ACK_LOW);
  assign bus.address = address;
  assign bus.done    = done;

endmodule
